// File: rtl/lcd_bus_pkg.sv
// Shared opcodes, masks, status bit positions and frame-buffer address
// geometry for the two-chip 128x64 graphic LCD bus responder.
package lcd_bus_pkg;

  localparam logic [7:0] CMD_DISP_OFF = 8'h3E;
  localparam logic [7:0] CMD_DISP_ON  = 8'h3F;
  localparam logic [7:0] CMD_SET_Y    = 8'h40;
  localparam logic [7:0] CMD_SET_PAGE = 8'hB8;
  localparam logic [7:0] CMD_START    = 8'hC0;

  localparam logic [7:0] MASK_SET_Y    = 8'hC0;
  localparam logic [7:0] MASK_SET_PAGE = 8'hF8;
  localparam logic [7:0] MASK_START    = 8'hC0;

  localparam int STAT_BUSY  = 7;
  localparam int STAT_OFF   = 5;
  localparam int STAT_RESET = 4;

  localparam int FB_HALF_W   = 1;
  localparam int FB_PAGE_W   = 3;
  localparam int FB_COL_W    = 6;
  localparam int HALF_ADDR_W = FB_PAGE_W + FB_COL_W;
  localparam int FB_ADDR_W   = FB_HALF_W + HALF_ADDR_W;

  typedef enum logic [2:0] {
    OP_ILLEGAL,
    OP_DISP_OFF,
    OP_DISP_ON,
    OP_SET_Y,
    OP_SET_PAGE,
    OP_START
  } instr_op_e;

  // Exact matches are tested first so 0x3E/0x3F never fall into a masked class.
  function automatic instr_op_e decodeInstr(input logic [7:0] b);
    instr_op_e op;
    op = OP_ILLEGAL;
    if (b == CMD_DISP_OFF)                      op = OP_DISP_OFF;
    else if (b == CMD_DISP_ON)                  op = OP_DISP_ON;
    else if ((b & MASK_SET_Y) == CMD_SET_Y)     op = OP_SET_Y;
    else if ((b & MASK_SET_PAGE) == CMD_SET_PAGE) op = OP_SET_PAGE;
    else if ((b & MASK_START) == CMD_START)     op = OP_START;
    return op;
  endfunction

endpackage

// File: rtl/lcd_half_ctrl.sv
// One 64-column half of the panel: page/column/start-line/display state,
// its 512-byte display RAM and the read output latch.
module lcd_half_ctrl
  import lcd_bus_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_panelRst,
  input  logic                   i_commit,
  input  logic                   i_di,
  input  logic                   i_rw,
  input  logic [7:0]             i_data,
  input  logic [HALF_ADDR_W-1:0] i_fbAddr,
  output logic [7:0]             o_latch,
  output logic [7:0]             o_fbData,
  output logic                   o_dispOn,
  output logic [5:0]             o_startLine
);

  logic [7:0]             r_ram [0:(1<<HALF_ADDR_W)-1];
  logic [2:0]             r_page;
  logic [5:0]             r_col;
  logic [5:0]             r_start;
  logic                   r_disp;
  logic [7:0]             r_latch;
  logic [7:0]             r_fbData;
  instr_op_e              w_op;
  logic [HALF_ADDR_W-1:0] w_addr;
  logic                   w_ramWe;

  assign w_op    = decodeInstr(i_data);
  assign w_addr  = {r_page, r_col};
  assign w_ramWe = i_commit && i_di && !i_rw;

  // RAM has no reset; the fb port reads before a same-cycle host write lands.
  always_ff @(posedge clk) begin
    if (w_ramWe) r_ram[w_addr] <= i_data;
    r_fbData <= r_ram[i_fbAddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_page  <= '0;
      r_col   <= '0;
      r_start <= '0;
      r_disp  <= 1'b0;
      r_latch <= '0;
    end else if (i_panelRst) begin
      r_disp  <= 1'b0;
      r_start <= '0;
    end else if (i_commit) begin
      if (!i_rw && !i_di) begin
        case (w_op)
          OP_DISP_OFF: r_disp <= 1'b0;
          OP_DISP_ON:  r_disp <= 1'b1;
          OP_SET_Y: begin
            r_col   <= i_data[5:0];
            r_latch <= r_ram[{r_page, i_data[5:0]}];
          end
          OP_SET_PAGE: begin
            r_page  <= i_data[2:0];
            r_latch <= r_ram[{i_data[2:0], r_col}];
          end
          OP_START: r_start <= i_data[5:0];
          default: ;
        endcase
      end else if (i_di) begin
        r_col <= r_col + 6'd1;
        if (i_rw) r_latch <= r_ram[w_addr];
      end
    end
  end

  assign o_latch     = r_latch;
  assign o_fbData    = r_fbData;
  assign o_dispOn    = r_disp;
  assign o_startLine = r_start;

endmodule

// File: rtl/lcd_panel_responder.sv
// Receiving end of the two-chip LCD bus: synchronizes the async bus, commits
// transfers on the falling strobe edge and answers status/data reads.
module lcd_panel_responder
  import lcd_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 LCD_rst,
  input  logic [1:0]           LCD_cs,
  input  logic                 LCD_rw,
  input  logic                 LCD_di,
  input  logic                 LCD_en,
  input  logic [7:0]           LCD_data,
  output logic [7:0]           lcd_dout,
  output logic                 lcd_doe,
  input  logic [FB_ADDR_W-1:0] fb_addr,
  output logic [7:0]           fb_data,
  output logic [1:0]           disp_on,
  output logic [11:0]          start_line,
  output logic [CNT_W-1:0]     wr_count,
  output logic                 err_pulse
);

  localparam int BUS_W = 14;

  logic [BUS_W-1:0] r_sync [SYNC_STAGES];
  logic             r_enPrev;
  logic [7:0]       r_dout;
  logic             r_doe;
  logic             r_err;
  logic [CNT_W-1:0] r_wrCount;
  logic             r_fbHalf;

  logic [BUS_W-1:0] w_busIn;
  logic [BUS_W-1:0] w_bus;
  logic             w_lcdRst;
  logic [1:0]       w_cs;
  logic             w_rw;
  logic             w_di;
  logic             w_en;
  logic [7:0]       w_data;
  logic             w_fall;
  logic             w_rise;
  logic             w_panelRst;
  logic             w_protoErr;
  logic             w_accept;
  logic             w_lo;
  logic [7:0]       w_status;
  logic [7:0]       w_resp;
  instr_op_e        w_op;
  logic [1:0]       w_dispOn;
  logic [7:0]       w_latch [2];
  logic [7:0]       w_fbData [2];
  logic [5:0]       w_startLine [2];

  assign w_busIn = {LCD_rst, LCD_cs, LCD_rw, LCD_di, LCD_en, LCD_data};

  // Clearing the synchronizer and r_enPrev on rst drops any strobe in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_busIn;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_bus      = r_sync[SYNC_STAGES-1];
  assign w_lcdRst   = w_bus[13];
  assign w_cs       = w_bus[12:11];
  assign w_rw       = w_bus[10];
  assign w_di       = w_bus[9];
  assign w_en       = w_bus[8];
  assign w_data     = w_bus[7:0];
  assign w_panelRst = !w_lcdRst;
  assign w_fall     = r_enPrev && !w_en;
  assign w_rise     = !r_enPrev && w_en;
  assign w_op       = decodeInstr(w_data);

  assign w_protoErr = (w_cs == 2'b00) || (w_rw && (w_cs == 2'b11)) ||
                      (!w_rw && !w_di && (w_op == OP_ILLEGAL));
  assign w_accept   = w_fall && !w_panelRst && !w_protoErr;
  assign w_lo       = w_cs[1] && !w_cs[0];

  always_comb begin
    w_status              = '0;
    w_status[STAT_BUSY]   = 1'b0;
    w_status[STAT_OFF]    = !w_dispOn[w_lo];
    w_status[STAT_RESET]  = w_panelRst;
    w_resp                = w_di ? w_latch[w_lo] : w_status;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enPrev  <= 1'b0;
      r_dout    <= '0;
      r_doe     <= 1'b0;
      r_err     <= 1'b0;
      r_wrCount <= '0;
      r_fbHalf  <= 1'b0;
    end else begin
      r_enPrev <= w_en;
      r_err    <= w_fall && !w_panelRst && w_protoErr;
      r_fbHalf <= fb_addr[FB_ADDR_W-1];
      if (w_rise && w_rw) begin
        r_doe  <= 1'b1;
        r_dout <= w_resp;
      end else if (w_fall) begin
        r_doe <= 1'b0;
      end
      if (w_accept && w_di && !w_rw && (r_wrCount != '1))
        r_wrCount <= r_wrCount + 1'b1;
    end
  end

  for (genvar h = 0; h < 2; h++) begin : g_half
    lcd_half_ctrl u_half (
      .clk         (clk),
      .rst         (rst),
      .i_panelRst  (w_panelRst),
      .i_commit    (w_accept && w_cs[h]),
      .i_di        (w_di),
      .i_rw        (w_rw),
      .i_data      (w_data),
      .i_fbAddr    (fb_addr[HALF_ADDR_W-1:0]),
      .o_latch     (w_latch[h]),
      .o_fbData    (w_fbData[h]),
      .o_dispOn    (w_dispOn[h]),
      .o_startLine (w_startLine[h])
    );
  end

  assign lcd_dout   = r_dout;
  assign lcd_doe    = r_doe;
  assign err_pulse  = r_err;
  assign wr_count   = r_wrCount;
  assign disp_on    = w_dispOn;
  assign start_line = {w_startLine[1], w_startLine[0]};
  assign fb_data    = w_fbData[r_fbHalf];

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Self-checking bench for lcd_panel_responder: directed scenarios plus a
// randomized bus sequence checked against an array-based panel model.
module tb_lcd_panel_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        LCD_rst;
  logic [1:0]  LCD_cs;
  logic        LCD_rw;
  logic        LCD_di;
  logic        LCD_en;
  logic [7:0]  LCD_data;
  logic [7:0]  lcd_dout;
  logic        lcd_doe;
  logic [9:0]  fb_addr;
  logic [7:0]  fb_data;
  logic [1:0]  disp_on;
  logic [11:0] start_line;
  logic [15:0] wr_count;
  logic        err_pulse;

  int checks = 0;
  int passes = 0;
  int errSeen = 0;

  // Reference model of the panel as seen from the bus
  logic [7:0] mRam [1024];
  bit         mWritten [1024];
  logic [2:0] mPage [2];
  logic [5:0] mCol [2];
  logic [5:0] mStart [2];
  bit         mDisp [2];
  logic [7:0] mLatch [2];
  bit         mKnown [2];
  int         mWrCount;
  bit         mPanelRst;

  lcd_panel_responder #(.SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .LCD_rst(LCD_rst), .LCD_cs(LCD_cs), .LCD_rw(LCD_rw),
    .LCD_di(LCD_di), .LCD_en(LCD_en), .LCD_data(LCD_data), .lcd_dout(lcd_dout),
    .lcd_doe(lcd_doe), .fb_addr(fb_addr), .fb_data(fb_data), .disp_on(disp_on),
    .start_line(start_line), .wr_count(wr_count), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  // Counts error pulses so each transfer can report how many it caused
  always @(negedge clk) if (err_pulse === 1'b1) errSeen++;

  function automatic int mAddr(input int h, input logic [2:0] p, input logic [5:0] c);
    return h * 512 + int'(p) * 64 + int'(c);
  endfunction

  task automatic modelReset();
    for (int h = 0; h < 2; h++) begin
      mPage[h] = '0; mCol[h] = '0; mStart[h] = '0; mDisp[h] = 0;
      mLatch[h] = '0; mKnown[h] = 1;
    end
    for (int a = 0; a < 1024; a++) mWritten[a] = 0;
    mWrCount = 0;
  endtask

  function automatic logic [7:0] modelResponse(input logic [1:0] cs, input logic di);
    int lo;
    lo = (cs == 2'b10) ? 1 : 0;
    if (di) return mLatch[lo];
    return {2'b00, !mDisp[lo], mPanelRst, 4'b0000};
  endfunction

  function automatic bit modelRespKnown(input logic [1:0] cs, input logic di);
    return di ? mKnown[(cs == 2'b10) ? 1 : 0] : 1'b1;
  endfunction

  task automatic modelCommit(input logic [1:0] cs, input logic di, input logic rw,
                             input logic [7:0] d, output int expErr);
    int a;
    bit legal;
    expErr = 0;
    if (mPanelRst) return;
    if (cs == 2'b00 || (rw && cs == 2'b11)) begin expErr = 1; return; end
    legal = (d == 8'h3E) || (d == 8'h3F) || (d[7:6] == 2'b01) ||
            (d[7:3] == 5'b10111) || (d[7:6] == 2'b11);
    if (!rw && !di && !legal) begin expErr = 1; return; end
    for (int h = 0; h < 2; h++) begin
      if (cs[h]) begin
        a = mAddr(h, mPage[h], mCol[h]);
        if (!rw && !di) begin
          if (d == 8'h3E) mDisp[h] = 0;
          else if (d == 8'h3F) mDisp[h] = 1;
          else if (d[7:6] == 2'b11) mStart[h] = d[5:0];
          else begin
            if (d[7:6] == 2'b01) mCol[h] = d[5:0];
            else mPage[h] = d[2:0];
            a = mAddr(h, mPage[h], mCol[h]);
            mLatch[h] = mRam[a];
            mKnown[h] = mWritten[a];
          end
        end else if (!rw) begin
          mRam[a] = d;
          mWritten[a] = 1;
          mCol[h] = 6'((int'(mCol[h]) + 1) % 64);
        end else if (di) begin
          mLatch[h] = mRam[a];
          mKnown[h] = mWritten[a];
          mCol[h] = 6'((int'(mCol[h]) + 1) % 64);
        end
      end
    end
    if (!rw && di && mWrCount < 65535) mWrCount++;
  endtask

  // One full bus cycle: setup, strobe high (read data sampled), strobe low
  task automatic applyStimulus(input logic [1:0] cs, input logic di, input logic rw,
                               input logic [7:0] data, output logic [7:0] rd,
                               output logic rdoe, output int errDelta, output logic doeAfter);
    int errBefore;
    errBefore = errSeen;
    @(negedge clk);
    LCD_cs = cs; LCD_di = di; LCD_rw = rw; LCD_data = data;
    repeat (3) @(negedge clk);
    LCD_en = 1'b1;
    repeat (6) @(negedge clk);
    rd = lcd_dout; rdoe = lcd_doe;
    LCD_en = 1'b0;
    repeat (6) @(negedge clk);
    doeAfter = lcd_doe;
    errDelta = errSeen - errBefore;
  endtask

  task automatic xact(input logic [1:0] cs, input logic di, input logic rw,
                      input logic [7:0] data, output logic [7:0] rd, output logic rdoe,
                      output int errDelta, output int expErr);
    logic doeAfter;
    applyStimulus(cs, di, rw, data, rd, rdoe, errDelta, doeAfter);
    modelCommit(cs, di, rw, data, expErr);
  endtask

  task automatic fbRead(input logic [9:0] a, output logic [7:0] d);
    @(negedge clk);
    fb_addr = a;
    @(negedge clk);
    d = fb_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (4) @(negedge clk);
    checks++; if (disp_on !== 2'b00) $display("[TB] FAIL reset_disp_on: got %b want 00", disp_on); else passes++;
    checks++; if (start_line !== 12'h000) $display("[TB] FAIL reset_start_line: got %h want 000", start_line); else passes++;
    checks++; if (wr_count !== 16'h0000) $display("[TB] FAIL reset_wr_count: got %0d want 0", wr_count); else passes++;
    checks++; if (lcd_doe !== 1'b0) $display("[TB] FAIL reset_doe: got %b want 0", lcd_doe); else passes++;
    checks++; if (lcd_dout !== 8'h00) $display("[TB] FAIL reset_dout: got %h want 00", lcd_dout); else passes++;
    checks++; if (err_pulse !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", err_pulse); else passes++;
  endtask

  task automatic test_init();
    logic [7:0] rd; logic rdoe; int ed, ee, errTotal;
    logic [7:0] seq [4];
    seq = '{8'h3F, 8'hC0, 8'hB8, 8'h40};
    errTotal = 0;
    foreach (seq[i]) begin
      xact(2'b11, 1'b0, 1'b0, seq[i], rd, rdoe, ed, ee);
      errTotal += ed;
    end
    checks++; if (disp_on !== 2'b11) $display("[TB] FAIL init_disp_on: got %b want 11", disp_on); else passes++;
    checks++; if (start_line !== 12'h000) $display("[TB] FAIL init_start_line: got %h want 000", start_line); else passes++;
    checks++; if (errTotal !== 0) $display("[TB] FAIL init_err: got %0d pulses want 0", errTotal); else passes++;
  endtask

  task automatic test_write();
    logic [7:0] rd, fb; logic rdoe; int ed, ee;
    xact(2'b01, 1'b0, 1'b0, 8'hBA, rd, rdoe, ed, ee);
    xact(2'b01, 1'b0, 1'b0, 8'h4A, rd, rdoe, ed, ee);
    xact(2'b01, 1'b1, 1'b0, 8'hA5, rd, rdoe, ed, ee);
    fbRead(10'h08A, fb);
    checks++; if (fb !== 8'hA5) $display("[TB] FAIL write_fb: got %h want a5", fb); else passes++;
    checks++; if (wr_count !== 16'd1) $display("[TB] FAIL write_count: got %0d want 1", wr_count); else passes++;
    xact(2'b01, 1'b1, 1'b0, 8'h5A, rd, rdoe, ed, ee);
    fbRead(10'h08B, fb);
    checks++; if (fb !== 8'h5A) $display("[TB] FAIL write_col_advance: got %h want 5a", fb); else passes++;
  endtask

  task automatic test_wrap();
    logic [7:0] rd, fb; logic rdoe; int ed, ee;
    xact(2'b10, 1'b0, 1'b0, 8'hBB, rd, rdoe, ed, ee);
    xact(2'b10, 1'b0, 1'b0, 8'h7F, rd, rdoe, ed, ee);
    xact(2'b10, 1'b1, 1'b0, 8'h11, rd, rdoe, ed, ee);
    xact(2'b10, 1'b1, 1'b0, 8'h22, rd, rdoe, ed, ee);
    fbRead({1'b1, 3'd3, 6'd63}, fb);
    checks++; if (fb !== 8'h11) $display("[TB] FAIL wrap_col63: got %h want 11", fb); else passes++;
    fbRead({1'b1, 3'd3, 6'd0}, fb);
    checks++; if (fb !== 8'h22) $display("[TB] FAIL wrap_col0: got %h want 22", fb); else passes++;
    checks++; if (wr_count !== 16'd4) $display("[TB] FAIL wrap_count: got %0d want 4", wr_count); else passes++;
  endtask

  task automatic test_dummy_read();
    logic [7:0] rd, fb; logic rdoe; int ed, ee;
    xact(2'b01, 1'b0, 1'b0, 8'h45, rd, rdoe, ed, ee);
    xact(2'b01, 1'b1, 1'b0, 8'h66, rd, rdoe, ed, ee);
    xact(2'b01, 1'b1, 1'b0, 8'h77, rd, rdoe, ed, ee);
    xact(2'b01, 1'b0, 1'b0, 8'h45, rd, rdoe, ed, ee);
    xact(2'b01, 1'b1, 1'b1, 8'h00, rd, rdoe, ed, ee);
    checks++; if (rdoe !== 1'b1) $display("[TB] FAIL dummy_doe: got %b want 1", rdoe); else passes++;
    checks++; if (rd !== 8'h66) $display("[TB] FAIL dummy_first: got %h want 66", rd); else passes++;
    xact(2'b01, 1'b1, 1'b1, 8'h00, rd, rdoe, ed, ee);
    checks++; if (rd !== 8'h66) $display("[TB] FAIL dummy_second: got %h want 66", rd); else passes++;
    xact(2'b01, 1'b1, 1'b0, 8'h99, rd, rdoe, ed, ee);
    fbRead(10'h087, fb);
    checks++; if (fb !== 8'h99) $display("[TB] FAIL dummy_col_end: got %h want 99", fb); else passes++;
  endtask

  task automatic test_errors();
    logic [7:0] rd; logic rdoe; int ed, ee;
    xact(2'b01, 1'b0, 1'b0, 8'h00, rd, rdoe, ed, ee);
    checks++; if (ed !== 1) $display("[TB] FAIL err_illegal_instr: got %0d pulses want 1", ed); else passes++;
    xact(2'b00, 1'b1, 1'b0, 8'h12, rd, rdoe, ed, ee);
    checks++; if (ed !== 1) $display("[TB] FAIL err_no_cs: got %0d pulses want 1", ed); else passes++;
    checks++; if (wr_count !== 16'd7) $display("[TB] FAIL err_count: got %0d want 7", wr_count); else passes++;
    checks++; if (disp_on !== 2'b11) $display("[TB] FAIL err_disp_on: got %b want 11", disp_on); else passes++;
    xact(2'b11, 1'b1, 1'b1, 8'h00, rd, rdoe, ed, ee);
    checks++; if (ed !== 1) $display("[TB] FAIL err_read_both: got %0d pulses want 1", ed); else passes++;
  endtask

  task automatic test_panel_reset();
    logic [7:0] rd, fb; logic rdoe; int ed, ee;
    LCD_rst = 1'b0;
    mPanelRst = 1;
    for (int h = 0; h < 2; h++) begin mDisp[h] = 0; mStart[h] = '0; end
    repeat (6) @(negedge clk);
    checks++; if (disp_on !== 2'b00) $display("[TB] FAIL prst_disp_on: got %b want 00", disp_on); else passes++;
    checks++; if (start_line !== 12'h000) $display("[TB] FAIL prst_start: got %h want 000", start_line); else passes++;
    xact(2'b01, 1'b0, 1'b1, 8'h00, rd, rdoe, ed, ee);
    checks++; if (rd !== 8'h30) $display("[TB] FAIL prst_status: got %h want 30", rd); else passes++;
    xact(2'b01, 1'b1, 1'b0, 8'hEE, rd, rdoe, ed, ee);
    checks++; if (wr_count !== 16'd7) $display("[TB] FAIL prst_write_ignored: got %0d want 7", wr_count); else passes++;
    xact(2'b00, 1'b1, 1'b0, 8'hEE, rd, rdoe, ed, ee);
    checks++; if (ed !== 0) $display("[TB] FAIL prst_no_err: got %0d pulses want 0", ed); else passes++;
    LCD_rst = 1'b1;
    mPanelRst = 0;
    repeat (6) @(negedge clk);
    xact(2'b01, 1'b1, 1'b0, 8'h3C, rd, rdoe, ed, ee);
    fbRead(10'h088, fb);
    checks++; if (fb !== 8'h3C) $display("[TB] FAIL prst_pos_kept: got %h want 3c", fb); else passes++;
    xact(2'b11, 1'b0, 1'b0, 8'h3F, rd, rdoe, ed, ee);
  endtask

  task automatic test_random();
    logic [7:0] rd, d, expResp, fb; logic rdoe, di, rw; logic [1:0] cs; int ed, ee, k;
    bit known;
    for (int n = 0; n < 100; n++) begin
      cs = ($urandom_range(0, 99) < 4) ? 2'b00 : 2'($urandom_range(1, 3));
      k = $urandom_range(0, 9);
      d = 8'($urandom);
      di = 1'b0; rw = 1'b0;
      case (k)
        0: d = 8'hB8 | 8'($urandom_range(0, 7));
        1: d = 8'h40 | 8'($urandom_range(0, 63));
        2, 3, 4: di = 1'b1;
        5, 6: begin di = 1'b1; rw = 1'b1; end
        7: rw = 1'b1;
        8: d = 8'h3E | 8'($urandom_range(0, 1));
        default: d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 61))
                                                 : (8'hC0 | 8'($urandom_range(0, 63)));
      endcase
      expResp = modelResponse(cs, di);
      known = modelRespKnown(cs, di);
      xact(cs, di, rw, d, rd, rdoe, ed, ee);
      checks++; if (ed !== ee) $display("[TB] FAIL rand_err[%0d]: got %0d pulses want %0d", n, ed, ee); else passes++;
      if (rw) begin
        checks++; if (rdoe !== 1'b1) $display("[TB] FAIL rand_doe[%0d]: got %b want 1", n, rdoe); else passes++;
        if (known) begin
          checks++; if (rd !== expResp) $display("[TB] FAIL rand_read[%0d]: got %h want %h", n, rd, expResp); else passes++;
        end
      end
      checks++; if (disp_on !== {mDisp[1], mDisp[0]}) $display("[TB] FAIL rand_disp[%0d]: got %b want %b", n, disp_on, {mDisp[1], mDisp[0]}); else passes++;
      checks++; if (start_line !== {mStart[1], mStart[0]}) $display("[TB] FAIL rand_start[%0d]: got %h want %h", n, start_line, {mStart[1], mStart[0]}); else passes++;
      checks++; if (wr_count !== 16'(mWrCount)) $display("[TB] FAIL rand_count[%0d]: got %0d want %0d", n, wr_count, mWrCount); else passes++;
    end
    for (int a = 0; a < 1024; a++) begin
      if (mWritten[a]) begin
        fbRead(10'(a), fb);
        checks++; if (fb !== mRam[a]) $display("[TB] FAIL rand_fb[%0d]: got %h want %h", a, fb, mRam[a]); else passes++;
      end
    end
  endtask

  task automatic test_reset_midtransfer();
    logic [7:0] rd, fb; logic rdoe; int ed, ee, errBefore;
    @(negedge clk);
    LCD_cs = 2'b01; LCD_di = 1'b1; LCD_rw = 1'b1;
    repeat (3) @(negedge clk);
    LCD_en = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (lcd_doe !== 1'b1) $display("[TB] FAIL mid_doe_before: got %b want 1", lcd_doe); else passes++;
    errBefore = errSeen;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    LCD_en = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (8) @(negedge clk);
    checks++; if (lcd_doe !== 1'b0) $display("[TB] FAIL mid_doe: got %b want 0", lcd_doe); else passes++;
    checks++; if (lcd_dout !== 8'h00) $display("[TB] FAIL mid_dout: got %h want 00", lcd_dout); else passes++;
    checks++; if (wr_count !== 16'd0) $display("[TB] FAIL mid_count: got %0d want 0", wr_count); else passes++;
    checks++; if (disp_on !== 2'b00 || start_line !== 12'h000) $display("[TB] FAIL mid_state: got %b/%h want 00/000", disp_on, start_line); else passes++;
    checks++; if (errSeen - errBefore !== 0) $display("[TB] FAIL mid_err: got %0d pulses want 0", errSeen - errBefore); else passes++;
    xact(2'b01, 1'b1, 1'b0, 8'hC3, rd, rdoe, ed, ee);
    checks++; if (wr_count !== 16'd1) $display("[TB] FAIL mid_after_count: got %0d want 1", wr_count); else passes++;
    fbRead(10'h000, fb);
    checks++; if (fb !== 8'hC3) $display("[TB] FAIL mid_after_fb: got %h want c3", fb); else passes++;
  endtask

  initial begin
    rst = 1'b1; LCD_rst = 1'b1; LCD_cs = 2'b00; LCD_rw = 1'b0; LCD_di = 1'b0;
    LCD_en = 1'b0; LCD_data = 8'h00; fb_addr = '0; mPanelRst = 0;
    modelReset();
    test_reset();
    test_init();
    test_write();
    test_wrap();
    test_dummy_read();
    test_errors();
    test_panel_reset();
    test_random();
    test_reset_midtransfer();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
